// File: rtl/regfile_dumper.sv
// Walks register file addresses 0..DEPTH-1 and emits each register as an (addr, data, last) beat.
// Latency: one READ cycle plus at least one SEND cycle per emitted beat; a skipped register costs one cycle.
// Backpressure: out_valid holds the beat stable in SEND until out_ready; nothing depends combinationally on out_ready.
module regfile_dumper #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     skip_zero,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(DEPTH)-1:0] rf_rd_addr,
  input  logic [WIDTH-1:0]         rf_rd_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH)-1:0] out_addr,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_last
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [AW-1:0]  idx;
  logic           skip_q;

  logic           accept;     // start taken in IDLE
  logic           capture;    // register the read data and index
  logic           inc;        // advance the scan index
  logic           set_valid;  // a beat goes out next cycle
  logic           clr_valid;  // the current beat was accepted

  assign rf_rd_addr = idx;
  assign busy       = (state != IDLE);
  assign done       = (state == DONE);

  // Next-state and control decode; the scan stops at LAST_IDX so idx never wraps.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    capture   = 1'b0;
    inc       = 1'b0;
    set_valid = 1'b0;
    clr_valid = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = READ;
        end
      end
      READ: begin
        capture = 1'b1;
        if (skip_q && (rf_rd_data == '0)) begin
          if (idx == LAST_IDX) state_nxt = DONE;
          else                 inc       = 1'b1;
        end else begin
          set_valid = 1'b1;
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (out_valid && out_ready) begin
          clr_valid = 1'b1;
          if (idx == LAST_IDX) begin
            state_nxt = DONE;
          end else begin
            inc       = 1'b1;
            state_nxt = READ;
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State, scan index, latched skip flag and the registered output beat.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      idx       <= '0;
      skip_q    <= 1'b0;
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        idx    <= '0;
        skip_q <= skip_zero;
      end
      if (inc) begin
        idx <= idx + AW'(1);
      end
      if (capture) begin
        out_data <= rf_rd_data;
        out_addr <= idx;
        // last is only flagged on a beat that is actually emitted
        out_last <= set_valid && (idx == LAST_IDX);
      end
      if (set_valid) begin
        out_valid <= 1'b1;
      end else if (clr_valid) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_dumper.sv
// Self-checking bench for regfile_dumper: randomized and directed dumps against a list-based model.
// Expected beats are the nonskipped registers in address order; expected timing is derived from beat/skip/stall counts.
// Outputs are sampled 1 time unit after each rising edge; inputs are driven at the same point.
module tb_regfile_dumper;
  localparam int W  = 32;
  localparam int D  = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          skip_zero;
  logic          busy;
  logic          done;
  logic [AW-1:0] rf_rd_addr;
  logic [W-1:0]  rf_rd_data;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_addr;
  logic [W-1:0]  out_data;
  logic          out_last;

  logic [W-1:0]  regs [D];
  assign rf_rd_data = regs[rf_rd_addr];

  always #5 clk = ~clk;

  regfile_dumper #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .start(start), .skip_zero(skip_zero),
    .busy(busy), .done(done), .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .out_data(out_data), .out_last(out_last)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [W-1:0]  data;
    logic          last;
  } beat_t;

  int    n_pass = 0;
  int    n_total = 0;
  beat_t obs[$];
  beat_t exp_q[$];
  int    n_skip;
  int    done_cyc, done_cnt, stab_err, stalls, timeout, busy_after_done;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: every register in address order, minus zeros when skipping.
  task automatic build_model(input bit skip);
    beat_t b;
    exp_q.delete();
    n_skip = 0;
    for (int i = 0; i < D; i++) begin
      if (skip && regs[i] == '0) begin
        n_skip++;
      end else begin
        b.addr = AW'(i);
        b.data = regs[i];
        b.last = (i == D - 1);
        exp_q.push_back(b);
      end
    end
  endtask

  // Runs one dump and records what the sink sees. ready_mode: 0 always ready, 1 random, 2 stall one beat.
  task automatic run_dump(input bit skip, input int ready_mode, input int stall_beat, input int stall_len,
                          input int restart_beat, input bit start_at_done);
    int    cyc;
    int    stall_used;
    bit    held;
    bit    seen_done;
    bit    restarted;
    beat_t hold_b;
    beat_t b;
    obs.delete();
    done_cyc = -1; done_cnt = 0; stab_err = 0; stalls = 0; timeout = 1; busy_after_done = -1;
    cyc = 0; stall_used = 0; held = 0; seen_done = 0; restarted = 0; hold_b = '0;
    start = 1'b1; skip_zero = skip; out_ready = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      tick();
      cyc++;
      start = 1'b0;
      skip_zero = 1'($urandom_range(0, 1));
      if (held && !(out_valid && {out_addr, out_data, out_last} == hold_b)) stab_err++;
      if (seen_done) begin
        if (done) done_cnt++;
        busy_after_done = int'(busy);
        timeout = 0;
        break;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        seen_done = 1;
        if (start_at_done) start = 1'b1;
      end
      if (ready_mode == 1) out_ready = 1'($urandom_range(0, 1));
      else if (ready_mode == 2 && out_valid && obs.size() == stall_beat && stall_used < stall_len) begin
        out_ready = 1'b0;
        stall_used++;
      end else out_ready = 1'b1;
      if (!restarted && restart_beat >= 0 && out_valid && obs.size() == restart_beat) begin
        start = 1'b1;
        restarted = 1;
      end
      held = out_valid && !out_ready;
      hold_b = {out_addr, out_data, out_last};
      if (out_valid && !out_ready) stalls++;
      if (out_valid && out_ready) begin
        b.addr = out_addr; b.data = out_data; b.last = out_last;
        obs.push_back(b);
      end
    end
    start = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; skip_zero = 1'b0; out_ready = 1'b1;
    tick(); tick();
    n_total++;
    if ({busy, done, out_valid, out_last} !== 4'b0000)
      $display("FAIL reset_flags: got busy/done/valid/last=%b want 0000", {busy, done, out_valid, out_last});
    else n_pass++;
    n_total++;
    if ({rf_rd_addr, out_addr, out_data} !== '0)
      $display("FAIL reset_values: got rd_addr=%0d addr=%0d data=%h want 0", rf_rd_addr, out_addr, out_data);
    else n_pass++;
    rst = 1'b1;
    tick();
    n_total++;
    if (busy !== 1'b0) $display("FAIL reset_idle: got busy=%b want 0", busy);
    else n_pass++;
  endtask

  task automatic test_full_dump();
    for (int i = 0; i < D; i++) regs[i] = W'(i * 3);
    build_model(1'b0);
    run_dump(1'b0, 0, -1, 0, -1, 1'b0);
    n_total++;
    if (obs.size() != 32) $display("FAIL full_count: got %0d want 32", obs.size()); else n_pass++;
    for (int i = 0; i < exp_q.size(); i++) begin
      n_total++;
      if (i < obs.size() && obs[i] === exp_q[i]) n_pass++;
      else if (i < obs.size()) $display("FAIL full_beat%0d: got %h want %h", i, obs[i], exp_q[i]);
      else $display("FAIL full_beat%0d: got none want %h", i, exp_q[i]);
    end
    n_total++;
    if (done_cyc != 65) $display("FAIL full_done_cycle: got %0d want 65", done_cyc); else n_pass++;
    n_total++;
    if (done_cnt != 1 || timeout != 0) $display("FAIL full_done_count: got %0d (timeout %0d) want 1", done_cnt, timeout);
    else n_pass++;
  endtask

  task automatic test_skip_zero();
    for (int i = 0; i < D; i++) regs[i] = '0;
    regs[5] = 32'h0000_00A5;
    regs[31] = 32'hDEAD_BEEF;
    build_model(1'b1);
    run_dump(1'b1, 0, -1, 0, -1, 1'b0);
    n_total++;
    if (obs.size() != 2) $display("FAIL skip_count: got %0d want 2", obs.size()); else n_pass++;
    for (int i = 0; i < exp_q.size(); i++) begin
      n_total++;
      if (i < obs.size() && obs[i] === exp_q[i]) n_pass++;
      else if (i < obs.size()) $display("FAIL skip_beat%0d: got %h want %h", i, obs[i], exp_q[i]);
      else $display("FAIL skip_beat%0d: got none want %h", i, exp_q[i]);
    end
    n_total++;
    if (done_cnt != 1 || done_cyc != 1 + 2 * 2 + n_skip)
      $display("FAIL skip_done: got count %0d cycle %0d want 1 at %0d", done_cnt, done_cyc, 1 + 4 + n_skip);
    else n_pass++;
    // last register skipped: the only beat must not carry last
    for (int i = 0; i < D; i++) regs[i] = '0;
    regs[7] = 32'h1;
    run_dump(1'b1, 0, -1, 0, -1, 1'b0);
    n_total++;
    if (obs.size() != 1) $display("FAIL skiplast_count: got %0d want 1", obs.size()); else n_pass++;
    n_total++;
    if (obs.size() < 1 || obs[0] !== {5'd7, 32'h1, 1'b0})
      $display("FAIL skiplast_beat: got %h want %h", (obs.size() > 0) ? obs[0] : '0, {5'd7, 32'h1, 1'b0});
    else n_pass++;
    n_total++;
    if (done_cnt != 1 || done_cyc != 1 + 2 + 31)
      $display("FAIL skiplast_done: got count %0d cycle %0d want 1 at 34", done_cnt, done_cyc);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < D; i++) regs[i] = W'(i * 3);
    build_model(1'b0);
    run_dump(1'b0, 2, 3, 5, -1, 1'b0);
    n_total++;
    if (stalls != 5 || stab_err != 0) $display("FAIL bp_hold: got stalls %0d unstable %0d want 5 and 0", stalls, stab_err);
    else n_pass++;
    n_total++;
    if (obs.size() != 32) $display("FAIL bp_count: got %0d want 32", obs.size()); else n_pass++;
    for (int i = 0; i < exp_q.size(); i++) begin
      n_total++;
      if (i < obs.size() && obs[i] === exp_q[i]) n_pass++;
      else if (i < obs.size()) $display("FAIL bp_beat%0d: got %h want %h", i, obs[i], exp_q[i]);
      else $display("FAIL bp_beat%0d: got none want %h", i, exp_q[i]);
    end
    n_total++;
    if (done_cyc != 70) $display("FAIL bp_done_cycle: got %0d want 70", done_cyc); else n_pass++;
  endtask

  task automatic test_reset_mid_dump();
    bit found;
    int bad;
    found = 0; bad = 0;
    for (int i = 0; i < D; i++) regs[i] = W'(i * 3 + 1);
    start = 1'b1; skip_zero = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 200; k++) begin
      tick();
      start = 1'b0;
      if (out_valid && out_addr == 5'd10) begin found = 1; break; end
    end
    n_total++;
    if (!found) $display("FAIL midrst_reach: got no beat 10 want beat 10"); else n_pass++;
    rst = 1'b0;
    tick();
    n_total++;
    if ({out_valid, busy, done} !== 3'b000)
      $display("FAIL midrst_clear: got valid/busy/done=%b want 000", {out_valid, busy, done});
    else n_pass++;
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (done || busy || out_valid) bad++;
    end
    n_total++;
    if (bad != 0) $display("FAIL midrst_quiet: got %0d active cycles want 0", bad); else n_pass++;
    build_model(1'b0);
    run_dump(1'b0, 0, -1, 0, -1, 1'b0);
    n_total++;
    if (obs.size() != 32 || obs[0] !== exp_q[0])
      $display("FAIL midrst_restart: got %0d beats first %h want 32 first %h", obs.size(),
               (obs.size() > 0) ? obs[0] : '0, exp_q[0]);
    else n_pass++;
    n_total++;
    if (done_cyc != 65 || done_cnt != 1) $display("FAIL midrst_done: got cycle %0d count %0d want 65 1", done_cyc, done_cnt);
    else n_pass++;
  endtask

  task automatic test_start_while_busy();
    for (int i = 0; i < D; i++) regs[i] = W'(i * 3);
    build_model(1'b0);
    run_dump(1'b0, 0, -1, 0, 4, 1'b1);
    n_total++;
    if (obs.size() != 32 || obs[31] !== exp_q[31])
      $display("FAIL busy_start_beats: got %0d beats want 32", obs.size());
    else n_pass++;
    n_total++;
    if (done_cnt != 1 || done_cyc != 65) $display("FAIL busy_start_done: got count %0d cycle %0d want 1 at 65", done_cnt, done_cyc);
    else n_pass++;
    n_total++;
    if (busy_after_done != 0) $display("FAIL start_at_done: got busy=%0d want 0", busy_after_done); else n_pass++;
    // a start one cycle later, in IDLE, is accepted
    run_dump(1'b0, 0, -1, 0, -1, 1'b0);
    n_total++;
    if (obs.size() != 32 || done_cnt != 1) $display("FAIL start_after_done: got %0d beats %0d done want 32 1", obs.size(), done_cnt);
    else n_pass++;
  endtask

  task automatic test_random();
    bit skip;
    for (int it = 0; it < 4; it++) begin
      for (int i = 0; i < D; i++) regs[i] = ($urandom_range(0, 9) < 4) ? '0 : W'($urandom);
      skip = 1'($urandom_range(0, 1));
      build_model(skip);
      run_dump(skip, 1, -1, 0, -1, 1'b0);
      n_total++;
      if (obs.size() != exp_q.size()) $display("FAIL rand%0d_count: got %0d want %0d", it, obs.size(), exp_q.size());
      else n_pass++;
      for (int i = 0; i < exp_q.size(); i++) begin
        n_total++;
        if (i < obs.size() && obs[i] === exp_q[i]) n_pass++;
        else if (i < obs.size()) $display("FAIL rand%0d_beat%0d: got %h want %h", it, i, obs[i], exp_q[i]);
        else $display("FAIL rand%0d_beat%0d: got none want %h", it, i, exp_q[i]);
      end
      n_total++;
      if (stab_err != 0) $display("FAIL rand%0d_stable: got %0d unstable cycles want 0", it, stab_err); else n_pass++;
      n_total++;
      if (done_cnt != 1 || done_cyc != 1 + 2 * exp_q.size() + n_skip + stalls)
        $display("FAIL rand%0d_done: got count %0d cycle %0d want 1 at %0d", it, done_cnt, done_cyc,
                 1 + 2 * exp_q.size() + n_skip + stalls);
      else n_pass++;
    end
  endtask

  initial begin
    for (int i = 0; i < D; i++) regs[i] = '0;
    test_reset();
    test_full_dump();
    test_skip_zero();
    test_backpressure();
    test_reset_mid_dump();
    test_start_while_busy();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/regfile_dumper.md
REGFILE_DUMPER -- requirements
Module: regfile_dumper

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, meaning register data width in bits.
REQ-002 The module SHALL have parameter DEPTH, default 32, meaning number of registers scanned; the address width is $clog2(DEPTH).
REQ-003 The module SHALL have port clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: reset is synchronous and active-low.
REQ-005 The module SHALL have port start, input, 1 bit: single-cycle request to begin a dump.
REQ-006 The module SHALL have port skip_zero, input, 1 bit: when set, registers holding zero are not emitted; sampled only when start is accepted.
REQ-007 The module SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-008 The module SHALL have port done, output, 1 bit: one-cycle pulse at the end of a dump.
REQ-009 The module SHALL have port rf_rd_addr, output, $clog2(DEPTH) bits: register-file read address, driven combinationally from the scan index.
REQ-010 The module SHALL have port rf_rd_data, input, WIDTH bits: asynchronous register-file read data for rf_rd_addr.
REQ-011 The module SHALL have port out_valid, output, 1 bit: output beat valid.
REQ-012 The module SHALL have port out_ready, input, 1 bit: sink accepts the beat.
REQ-013 The module SHALL have port out_addr, output, $clog2(DEPTH) bits: register index of the current beat.
REQ-014 The module SHALL have port out_data, output, WIDTH bits: register value of the current beat.
REQ-015 The module SHALL have port out_last, output, 1 bit: high with a valid beat whose out_addr equals DEPTH-1.

Function
REQ-016 The FSM SHALL use the states IDLE, READ, SEND and DONE.
REQ-017 IDLE SHALL behave as follows: on start=1, load idx=0, latch skip_zero, and go to READ the next cycle; otherwise remain in IDLE.
REQ-018 start SHALL be ignored in every state other than IDLE.
REQ-019 rf_rd_addr SHALL equal idx in all states; it is 0 in IDLE after reset.
REQ-020 READ SHALL register out_data=rf_rd_data and out_addr=idx.
REQ-021 In READ, if skip is latched and rf_rd_data==0, the FSM SHALL do the following: if idx==DEPTH-1, go to DONE; otherwise increment idx and stay in READ. No beat is emitted.
REQ-022 In READ, if no skip applies, the FSM SHALL go to SEND with out_valid=1 from the next cycle.
REQ-023 In SEND, out_valid, out_addr, out_data and out_last SHALL stay stable until out_valid && out_ready.
REQ-024 On a SEND handshake, the FSM SHALL clear out_valid; if idx==DEPTH-1, go to DONE; otherwise increment idx and go to READ.
REQ-025 Minimum throughput SHALL be one beat per 2 cycles (READ+SEND); out_ready held high SHALL give a full dump of 2*DEPTH+1 cycles from start to the done pulse.
REQ-026 DONE SHALL assert done for exactly one cycle and then go to IDLE; busy is high in DONE.
REQ-027 out_last SHALL be asserted only on the beat with out_addr==DEPTH-1; if that register is skipped, no beat carries out_last, and done alone marks the end.
REQ-028 The scan index idx SHALL never wrap: a dump covers addresses 0..DEPTH-1 exactly once.
REQ-029 out_valid SHALL be a registered output, and no output SHALL depend combinationally on out_ready.
REQ-030 A start arriving on the same cycle as the done pulse SHALL be ignored; a start one cycle later, in IDLE, SHALL be accepted.

Reset
REQ-031 When rst=0 at a rising clk edge, the module SHALL go to IDLE with idx=0, out_valid=0, out_addr=0, out_data=0, out_last=0, done=0, busy=0, and the latched skip cleared.
REQ-032 Reset SHALL take priority over all other inputs, including when it is asserted mid-dump; no partial beat remains valid afterwards, and done is not pulsed.

Verification
REQ-033 The bench SHALL cover a full dump: regfile[i]=i*3, skip_zero=0, out_ready=1 -> 32 beats with addr 0..31 and data 0,3,...,93, out_last only on addr 31, and done 65 cycles after start.
REQ-034 The bench SHALL cover skip-zero: only regs 5 and 31 nonzero (0xA5, 0xDEADBEEF), skip_zero=1 -> exactly 2 beats, (5,0xA5) and (31,0xDEADBEEF,last=1), then done.
REQ-035 The bench SHALL cover a skipped last register: only reg 7=1, skip_zero=1 -> a single beat (7,1,last=0), followed by a done pulse.
REQ-036 The bench SHALL cover backpressure: out_ready low for 5 cycles on beat 3 -> out_valid, out_addr=3 and out_data held stable, with no beat lost or duplicated.
REQ-037 The bench SHALL cover reset mid-dump: rst=0 while in SEND for beat 10 -> the next cycle has out_valid=0, busy=0 and no done pulse; a subsequent start restarts at addr 0.
REQ-038 The bench SHALL cover start while busy: pulse start during beat 4 -> ignored, the dump completes normally, and exactly one done pulse occurs.
